rs_ff_driver: RTL and testbench
===============================

Name: rs_ff_driver

Overview:
- Command-driven transmitter for the clocked RS flip-flop (`rs_ff`); it generates the R/S stimulus that the flip-flop consumes.
- Accepts SET / RESET / HOLD / TOGGLE commands over a valid/ready handshake.
- Drives R/S pulses of programmable width, never drives R=S=1, then checks the flip-flop's Q/Qn response.
- Sits between a controller or sequencer and an `rs_ff` instance.

Parameters:
- LEN_W, 8, width of the command pulse-length field.
- SETTLE_CYC, 2, cycles with R=S=0 between the end of drive and the Q/Qn check (≥1).
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_op  in  2  00 HOLD, 01 SET, 10 RESET, 11 TOGGLE.
- cmd_len  in  LEN_W  drive length in cycles; 0 is treated as 1.
- q_in  in  1  Q from the flip-flop.
- qn_in  in  1  Qn from the flip-flop.
- r_out  out  1  R to the flip-flop (registered).
- s_out  out  1  S to the flip-flop (registered).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  valid only with done; 1 = response mismatch.
- err_cnt  out  ERRCNT_W  saturating count of err pulses.

Behaviour:
- Reset: state=IDLE; r_out=0, s_out=0, done=0, err=0, err_cnt=0, busy=0. cmd_ready=0 while rst=1.
- State machine:
  - IDLE: cmd_ready=1.
    - Accept on cmd_valid&&cmd_ready.
    - Latch op and len_eff = (cmd_len==0 ? 1 : cmd_len).
    - Latch expected Q: SET→1; RESET→0; HOLD→q_in sampled at accept; TOGGLE→~q_in sampled at accept.
    - Go to DRIVE.
  - DRIVE: s_out=1 for SET, or for TOGGLE with expected=1. r_out=1 for RESET, or for TOGGLE with expected=0. HOLD drives R=S=0.
    - Outputs are registered, so they are asserted from the cycle after accept.
    - Hold for exactly len_eff cycles via a down-counter, then go to SETTLE.
  - SETTLE: r_out=s_out=0 for SETTLE_CYC cycles, then go to CHECK.
  - CHECK: one cycle.
    - done=1.
    - err=1 if q_in!=expected or q_in==qn_in.
    - err_cnt += err, saturating at all-ones.
    - Return to IDLE.
- Latency: accept at cycle T → done at T+len_eff+SETTLE_CYC+1.
- Back-to-back: the next command is accepted in the first IDLE cycle after CHECK; minimum command period = len_eff+SETTLE_CYC+2.
- Invariant: r_out&s_out is never 1 in any cycle, including across reset and op changes.
- cmd_op/cmd_len are ignored unless accepted; changes to them while busy have no effect.
- cmd_len at its maximum (all-ones) drives 2^LEN_W−1 cycles with no wrap.
- Reset mid-operation: next cycle state=IDLE and r_out=s_out=0. No done is produced for the aborted command. err_cnt clears.
- done and err are 0 outside CHECK.

Decomposition:
- Package rs_pkg:
  - op encodings OP_HOLD/OP_SET/OP_RESET/OP_TOGGLE;
  - state encoding IDLE/DRIVE/SETTLE/CHECK.
- Sub-module: one natural sub-module, rs_pulse_timer, a loadable down-counter with a zero flag. It is reused for the drive length and the settle count.

Test Plan:
- Use rs_ff_driver connected to rs_ff throughout.
- Reset then SET, len=3 → s_out high for exactly 3 cycles, r_out=0, done at T+6, err=0, Q=1, Qn=0.
- After SET, RESET with len=0 → r_out high for 1 cycle, done at T+4, Q=0, err=0.
- TOGGLE twice from Q=0, len=2 each → first drives S and gives Q=1; second drives R and gives Q=0. err=0 both times; no cycle with r_out&s_out.
- HOLD with len=5, Q=1 → r_out=s_out=0 for 5 cycles; done at T+8; Q stays 1; err=0.
- Force q_in stuck at 0 and issue SET → done with err=1, err_cnt=1. Repeat 300 times with ERRCNT_W=8 → err_cnt saturates at 255.
- Assert rst during DRIVE of SET with len=10 → r_out=s_out=0 the next cycle, no done, cmd_ready=1 after rst deasserts. A new command is accepted normally.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared encodings for the RS flip-flop command driver: command opcodes and FSM states.
package rs_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] CHECK  = 2'd3;

endpackage

// File: rtl/rs_pulse_timer.sv
// Loadable down-counter with a zero flag; shared by the drive-length and settle phases.
module rs_pulse_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rs_ff_driver.sv
// Command-driven R/S stimulus generator for a clocked RS flip-flop, with Q/Qn response check.
module rs_ff_driver
  import rs_pkg::*;
#(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned ERRCNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                q_in,
  input  logic                qn_in,
  output logic                r_out,
  output logic                s_out,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CntW = (LEN_W > SetW) ? LEN_W : SetW;

  logic [1:0]          state_q, state_d;
  logic                exp_q, exp_d;
  logic                r_q, r_d, s_q, s_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                tmr_load, tmr_dec, tmr_zero;
  logic [CntW-1:0]     tmr_val;
  logic [LEN_W-1:0]    len_m1;

  // Timer holds (cycles - 1); zero flag marks the last cycle of a phase.
  assign len_m1 = (cmd_len == '0) ? '0 : cmd_len - 1'b1;

  rs_pulse_timer #(
    .W(CntW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    r_d       = r_q;
    s_d       = s_q;
    err_cnt_d = err_cnt_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_HOLD:   exp_d = q_in;
            OP_SET:    exp_d = 1'b1;
            OP_RESET:  exp_d = 1'b0;
            OP_TOGGLE: exp_d = ~q_in;
          endcase
          // R and S are derived from mutually exclusive conditions.
          s_d      = (cmd_op == OP_SET)   || ((cmd_op == OP_TOGGLE) && !q_in);
          r_d      = (cmd_op == OP_RESET) || ((cmd_op == OP_TOGGLE) &&  q_in);
          tmr_load = 1'b1;
          tmr_val  = CntW'(len_m1);
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (tmr_zero) begin
          r_d      = 1'b0;
          s_d      = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = CntW'(SETTLE_CYC - 1);
          state_d  = SETTLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) begin
          state_d = CHECK;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CHECK: begin
        done = 1'b1;
        err  = (q_in != exp_q) || (q_in == qn_in);
        if (err && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        r_d     = 1'b0;
        s_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      exp_q     <= 1'b0;
      r_q       <= 1'b0;
      s_q       <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      r_q       <= r_d;
      s_q       <= s_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign r_out     = r_q;
  assign s_out     = s_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rs_ff_driver.sv
// Bench for rs_ff_driver driving a behavioural clocked RS flip-flop, with a stuck-at fault hook.
module tb_rs_ff_driver;

  localparam int unsigned LEN_W      = 8;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned ERRCNT_W   = 8;
  localparam int          ErrMax     = 255;

  localparam logic [1:0] T_HOLD   = 2'b00;
  localparam logic [1:0] T_SET    = 2'b01;
  localparam logic [1:0] T_RESET  = 2'b10;
  localparam logic [1:0] T_TOGGLE = 2'b11;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [LEN_W-1:0]    cmd_len;
  logic                q_in, qn_in;
  logic                r_out, s_out, busy, done, err;
  logic [ERRCNT_W-1:0] err_cnt;

  logic q_ff = 1'b0;
  logic stuck = 1'b0;
  int   cyc = 0;
  int   overlap = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_acc = 0;
  int   model_ecnt = 0;

  always #5 clk = ~clk;

  // Behavioural clocked RS flip-flop (plant).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_out === 1'b1) q_ff <= 1'b1;
    else if (r_out === 1'b1) q_ff <= 1'b0;
  end

  always @(negedge clk) begin
    if ((r_out === 1'b1) && (s_out === 1'b1)) overlap <= overlap + 1;
  end

  assign q_in  = stuck ? 1'b0 : q_ff;
  assign qn_in = stuck ? 1'b1 : ~q_ff;

  rs_ff_driver #(
    .LEN_W     (LEN_W),
    .SETTLE_CYC(SETTLE_CYC),
    .ERRCNT_W  (ERRCNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .q_in     (q_in),
    .qn_in    (qn_in),
    .r_out    (r_out),
    .s_out    (s_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  // Issue one command and check the whole transaction against the reference rules.
  task automatic run_cmd(input logic [1:0] op, input int len, input string name);
    int   le, k, wt;
    logic expq, ds, dr, eerr, es, er, ed, got;
    le = (len == 0) ? 1 : len;
    wt = 0;
    while ((cmd_ready !== 1'b1) && (wt < 64)) begin
      @(posedge clk); #1;
      wt++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready-wait: cmd_ready=%b required 1", name, cmd_ready);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    case (op)
      T_SET:   expq = 1'b1;
      T_RESET: expq = 1'b0;
      T_HOLD:  expq = q_in;
      default: expq = ~q_in;
    endcase
    ds   = (op != T_HOLD) && expq;
    dr   = (op != T_HOLD) && !expq;
    eerr = stuck ? expq : 1'b0;
    @(posedge clk); #1;
    last_acc = cyc;
    got = 1'b0;
    for (k = 1; (k <= le + int'(SETTLE_CYC) + 4) && !got; k++) begin
      es = ds && (k <= le);
      er = dr && (k <= le);
      ed = (k == le + int'(SETTLE_CYC) + 1);
      n_cmp++;
      if ({s_out, r_out, busy, done} !== {es, er, 1'b1, ed}) begin
        n_bad++;
        $display("FAIL %s cycle %0d: s,r,busy,done=%b%b%b%b required %b%b1%b",
                 name, k, s_out, r_out, busy, done, es, er, ed);
      end
      if (done === 1'b1) begin
        got = 1'b1;
        n_cmp++;
        if (err !== eerr) begin
          n_bad++;
          $display("FAIL %s err: got %b required %b", name, err, eerr);
        end
        if (!stuck) begin
          n_cmp++;
          if ({q_in, qn_in} !== {expq, ~expq}) begin
            n_bad++;
            $display("FAIL %s q/qn: got %b%b required %b%b", name, q_in, qn_in, expq, ~expq);
          end
        end
      end
      // Garbage on the command bus while busy must be ignored.
      cmd_valid = 1'($urandom);
      cmd_op    = 2'($urandom);
      cmd_len   = LEN_W'($urandom);
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s done-timeout: no done within budget, required at cycle %0d",
               name, le + int'(SETTLE_CYC) + 1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_ecnt = (model_ecnt + int'(eerr) > ErrMax) ? ErrMax : model_ecnt + int'(eerr);
    n_cmp++;
    if ({busy, cmd_ready, done} !== 3'b010 || int'(err_cnt) != model_ecnt) begin
      n_bad++;
      $display("FAIL %s post: busy,ready,done=%b%b%b err_cnt=%0d required 010 err_cnt=%0d",
               name, busy, cmd_ready, done, err_cnt, model_ecnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = T_HOLD;
    cmd_len = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({cmd_ready, r_out, s_out, busy, done, err} !== 6'b0 || err_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset: ready,r,s,busy,done,err=%b%b%b%b%b%b err_cnt=%0d required all 0",
               cmd_ready, r_out, s_out, busy, done, err, err_cnt);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset-release: cmd_ready=%b required 1", cmd_ready);
    end
    model_ecnt = 0;
  endtask

  task automatic test_set();      run_cmd(T_SET, 3, "set_len3");     endtask
  task automatic test_reset_op(); run_cmd(T_RESET, 0, "reset_len0"); endtask

  task automatic test_toggle();
    run_cmd(T_TOGGLE, 2, "toggle1");
    run_cmd(T_TOGGLE, 2, "toggle2");
  endtask

  task automatic test_hold();
    run_cmd(T_SET, 1, "hold_pre_set");
    run_cmd(T_HOLD, 5, "hold_len5");
  endtask

  task automatic test_max_len(); run_cmd(T_RESET, 255, "reset_len255"); endtask

  task automatic test_back_to_back();
    int a;
    run_cmd(T_SET, 2, "b2b_first");
    a = last_acc;
    run_cmd(T_TOGGLE, 3, "b2b_second");
    n_cmp++;
    if (last_acc - a != 2 + int'(SETTLE_CYC) + 2) begin
      n_bad++;
      $display("FAIL back_to_back period: got %0d required %0d",
               last_acc - a, 2 + int'(SETTLE_CYC) + 2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 6)), "random");
    end
  endtask

  task automatic test_err_saturate();
    stuck = 1'b1;
    for (int i = 0; i < 300; i++) begin
      run_cmd(T_SET, 0, "stuck_set");
    end
    stuck = 1'b0;
    n_cmp++;
    if (int'(err_cnt) != ErrMax) begin
      n_bad++;
      $display("FAIL err_saturate: err_cnt=%0d required %0d", err_cnt, ErrMax);
    end
  endtask

  task automatic test_mid_reset();
    int seen_done;
    int wt;
    wt = 0;
    while ((cmd_ready !== 1'b1) && (wt < 64)) begin
      @(posedge clk); #1;
      wt++;
    end
    cmd_valid = 1'b1;
    cmd_op    = T_SET;
    cmd_len   = LEN_W'(10);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({s_out, r_out, busy} !== 3'b101) begin
      n_bad++;
      $display("FAIL mid_reset pre: s,r,busy=%b%b%b required 101", s_out, r_out, busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset ready_in_rst: cmd_ready=%b required 0", cmd_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({s_out, r_out, busy, done} !== 4'b0 || err_cnt !== '0) begin
      n_bad++;
      $display("FAIL mid_reset abort: s,r,busy,done=%b%b%b%b err_cnt=%0d required 0000 0",
               s_out, r_out, busy, done, err_cnt);
    end
    rst = 1'b0;
    model_ecnt = 0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset ready_after: cmd_ready=%b required 1", cmd_ready);
    end
    seen_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    n_cmp++;
    if (seen_done != 0) begin
      n_bad++;
      $display("FAIL mid_reset no_done: saw %0d done pulses required 0", seen_done);
    end
    run_cmd(T_RESET, 2, "after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_set();
    test_reset_op();
    test_toggle();
    test_hold();
    test_max_len();
    test_back_to_back();
    test_random();
    test_err_saturate();
    test_mid_reset();
    n_cmp++;
    if (overlap != 0) begin
      n_bad++;
      $display("FAIL rs_overlap: %0d cycles with r_out&s_out required 0", overlap);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
